// File: rtl/fifo_ep_mst_mc_pkg.sv
// Shared definitions for the multi-endpoint FT60x FIFO pointer manager:
// geometry constants, pointer types, per-endpoint state record and base-address helper.
package fifo_ep_mst_mc_pkg;

  localparam int CNT_CHANNLS = 4;
  localparam int CNT_BE      = 4;
  localparam int EP_MSZ      = 11;
  localparam int T_MSZ       = 14;
  localparam int PKT_WORDS   = 128;
  localparam int AF_LVL      = 8;
  localparam int EP_BASE_ADR = 0;

  localparam int EP_IDX_W = (CNT_CHANNLS > 1) ? $clog2(CNT_CHANNLS) : 1;
  localparam int PTR_W    = EP_MSZ + 1;
  localparam int PKT_W    = $clog2(PKT_WORDS + 1);

  typedef logic [PTR_W-1:0]    ptr_t;
  typedef logic [PKT_W-1:0]    pkt_t;
  typedef logic [EP_IDX_W-1:0] ep_idx_t;
  typedef logic [T_MSZ-1:0]    ram_adr_t;
  typedef logic [CNT_BE-1:0]   be_t;
  typedef logic [EP_MSZ-1:0]   ring_adr_t;

  localparam ptr_t PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam ptr_t RING_WORDS = {1'b1, {EP_MSZ{1'b0}}};
  localparam ptr_t AF_WORDS   = ptr_t'(AF_LVL);
  localparam pkt_t PKT_ONE    = {{(PKT_W-1){1'b0}}, 1'b1};
  localparam pkt_t PKT_FULL   = pkt_t'(PKT_WORDS);

  typedef struct packed {
    ptr_t wr_ptr;
    ptr_t cmt_ptr;
    ptr_t rd_ptr;
    pkt_t pkt_cnt;
    be_t  last_be;
    logic ovf;
    logic udf;
  } ep_state_t;

  function automatic ram_adr_t ep_base(input ep_idx_t idx);
    return ram_adr_t'(EP_BASE_ADR) + (ram_adr_t'(idx) << EP_MSZ);
  endfunction

endpackage

// File: rtl/fifo_ep_mst_mc_if.sv
// Request/status bundle between the FT60x bus FSM, the USB-side reader and the
// endpoint pointer manager; the manager takes the slave side.
interface fifo_ep_mst_mc_if import fifo_ep_mst_mc_pkg::*; ();

  logic                         i_mode;
  logic                         push_en;
  ep_idx_t                      push_ep;
  be_t                          push_be;
  logic                         push_last;
  logic                         pop_en;
  ep_idx_t                      pop_ep;
  logic                         ld_en;
  ep_idx_t                      ld_ep;
  ptr_t                         ld_ptr;
  logic [CNT_CHANNLS-1:0]       flush;
  ram_adr_t                     ram_wadr;
  logic                         ram_we;
  ram_adr_t                     ram_radr;
  be_t                          pop_be;
  logic [CNT_CHANNLS-1:0]       ep_empty;
  logic [CNT_CHANNLS-1:0]       ep_full;
  logic [CNT_CHANNLS-1:0]       ep_afull;
  logic [CNT_CHANNLS-1:0]       ep_pkt_avail;
  logic [CNT_CHANNLS*PTR_W-1:0] ep_count;
  logic [CNT_CHANNLS-1:0]       ovf;
  logic [CNT_CHANNLS-1:0]       udf;

  modport master (
    output i_mode, push_en, push_ep, push_be, push_last, pop_en, pop_ep,
           ld_en, ld_ep, ld_ptr, flush,
    input  ram_wadr, ram_we, ram_radr, pop_be, ep_empty, ep_full, ep_afull,
           ep_pkt_avail, ep_count, ovf, udf
  );

  modport slave (
    input  i_mode, push_en, push_ep, push_be, push_last, pop_en, pop_ep,
           ld_en, ld_ep, ld_ptr, flush,
    output ram_wadr, ram_we, ram_radr, pop_be, ep_empty, ep_full, ep_afull,
           ep_pkt_avail, ep_count, ovf, udf
  );

endinterface

// File: rtl/fifo_ep_mst_mc_ring.sv
// Pointer, packet-commit and flag logic for one endpoint ring buffer.
// Requests arrive already decoded for this endpoint and the active mode.
module fifo_ep_mst_mc_ring import fifo_ep_mst_mc_pkg::*; (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      push_i,
  input  be_t       push_be_i,
  input  logic      push_last_i,
  input  logic      pop_i,
  input  logic      ld_i,
  input  ptr_t      ld_ptr_i,
  input  logic      flush_i,
  output logic      push_ok_o,
  output ring_adr_t wr_adr_o,
  output ring_adr_t rd_adr_o,
  output be_t       last_be_o,
  output ptr_t      count_o,
  output logic      empty_o,
  output logic      full_o,
  output logic      afull_o,
  output logic      last_word_o,
  output logic      ovf_o,
  output logic      udf_o
);

  ep_state_t st_q, st_d;
  ptr_t      used_s, free_s, readable_s, wr_inc_s;
  pkt_t      pkt_inc_s;
  logic      full_s, push_ok_s, pop_ok_s, commit_s;

  // Derived occupancy and request qualification.
  always_comb begin
    used_s     = st_q.wr_ptr - st_q.rd_ptr;
    free_s     = RING_WORDS - used_s;
    readable_s = st_q.cmt_ptr - st_q.rd_ptr;
    full_s     = (st_q.wr_ptr[EP_MSZ] != st_q.rd_ptr[EP_MSZ]) &&
                 (st_q.wr_ptr[EP_MSZ-1:0] == st_q.rd_ptr[EP_MSZ-1:0]);
    wr_inc_s   = st_q.wr_ptr + PTR_ONE;
    pkt_inc_s  = st_q.pkt_cnt + PKT_ONE;
    push_ok_s  = push_i && !full_s && !flush_i;
    pop_ok_s   = pop_i && !ld_i && !flush_i && (readable_s != '0);
    commit_s   = push_ok_s && (push_last_i || (pkt_inc_s == PKT_FULL));
  end

  // Next state: flush wins, load wins over pop; pop sees the pre-push commit point.
  always_comb begin
    st_d = st_q;
    if (flush_i) begin
      st_d = '0;
    end else begin
      if (push_ok_s) begin
        st_d.wr_ptr  = wr_inc_s;
        st_d.last_be = push_be_i;
        st_d.cmt_ptr = commit_s ? wr_inc_s : st_q.cmt_ptr;
        st_d.pkt_cnt = commit_s ? '0 : pkt_inc_s;
      end else begin
        st_d.ovf = st_q.ovf | push_i;
      end
      if (ld_i) begin
        st_d.rd_ptr = ld_ptr_i;
      end else if (pop_ok_s) begin
        st_d.rd_ptr = st_q.rd_ptr + PTR_ONE;
      end else begin
        st_d.udf = st_q.udf | pop_i;
      end
    end
  end

  // Endpoint state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  assign push_ok_o   = push_ok_s;
  assign wr_adr_o    = st_q.wr_ptr[EP_MSZ-1:0];
  assign rd_adr_o    = st_q.rd_ptr[EP_MSZ-1:0];
  assign last_be_o   = st_q.last_be;
  assign count_o     = readable_s;
  assign empty_o     = (readable_s == '0);
  assign full_o      = full_s;
  assign afull_o     = (free_s <= AF_WORDS);
  assign last_word_o = (readable_s == PTR_ONE) && (st_q.cmt_ptr == st_q.wr_ptr);
  assign ovf_o       = st_q.ovf;
  assign udf_o       = st_q.udf;

endmodule

// File: rtl/fifo_ep_mst_mc.sv
// Multi-endpoint FT60x FIFO master pointer manager: decodes push/pop/load/flush
// per endpoint and muxes shared-RAM addresses, write strobe and pop byte enables.
module fifo_ep_mst_mc import fifo_ep_mst_mc_pkg::*; (
  input logic             fifoClk_i,
  input logic             fifoRstn_i,
  fifo_ep_mst_mc_if.slave bus_if
);

  logic [CNT_CHANNLS-1:0] ep_act_s, push_sel_s, pop_sel_s, ld_sel_s;
  logic [CNT_CHANNLS-1:0] push_ok_s, empty_s, full_s, afull_s, last_s, ovf_s, udf_s;
  ring_adr_t              wr_adr_s  [CNT_CHANNLS];
  ring_adr_t              rd_adr_s  [CNT_CHANNLS];
  be_t                    last_be_s [CNT_CHANNLS];
  ptr_t                   count_s   [CNT_CHANNLS];

  // In 245 mode only EP0 is live; requests to other endpoints are dropped here.
  always_comb begin
    ep_act_s   = '0;
    push_sel_s = '0;
    pop_sel_s  = '0;
    ld_sel_s   = '0;
    for (int k = 0; k < CNT_CHANNLS; k++) begin
      ep_act_s[k]   = !bus_if.i_mode || (k == 0);
      push_sel_s[k] = bus_if.push_en && ep_act_s[k] && (bus_if.push_ep == ep_idx_t'(k));
      pop_sel_s[k]  = bus_if.pop_en  && ep_act_s[k] && (bus_if.pop_ep  == ep_idx_t'(k));
      ld_sel_s[k]   = bus_if.ld_en   && ep_act_s[k] && (bus_if.ld_ep   == ep_idx_t'(k));
    end
  end

  for (genvar k = 0; k < CNT_CHANNLS; k++) begin : g_ep
    fifo_ep_mst_mc_ring u_ring (
      .clk_i       (fifoClk_i),
      .rst_n_i     (fifoRstn_i),
      .push_i      (push_sel_s[k]),
      .push_be_i   (bus_if.push_be),
      .push_last_i (bus_if.push_last),
      .pop_i       (pop_sel_s[k]),
      .ld_i        (ld_sel_s[k]),
      .ld_ptr_i    (bus_if.ld_ptr),
      .flush_i     (bus_if.flush[k]),
      .push_ok_o   (push_ok_s[k]),
      .wr_adr_o    (wr_adr_s[k]),
      .rd_adr_o    (rd_adr_s[k]),
      .last_be_o   (last_be_s[k]),
      .count_o     (count_s[k]),
      .empty_o     (empty_s[k]),
      .full_o      (full_s[k]),
      .afull_o     (afull_s[k]),
      .last_word_o (last_s[k]),
      .ovf_o       (ovf_s[k]),
      .udf_o       (udf_s[k])
    );
  end

  // RAM port addressing and the short-packet byte enables of the final word.
  always_comb begin
    bus_if.ram_we   = |push_ok_s;
    bus_if.ram_wadr = ep_base(bus_if.push_ep) + ram_adr_t'(wr_adr_s[bus_if.push_ep]);
    bus_if.ram_radr = ep_base(bus_if.pop_ep) + ram_adr_t'(rd_adr_s[bus_if.pop_ep]);
    bus_if.pop_be   = last_s[bus_if.pop_ep] ? last_be_s[bus_if.pop_ep] : '1;
  end

  // Status flags; inactive endpoints report all-zero flags.
  always_comb begin
    bus_if.ep_empty     = empty_s & ep_act_s;
    bus_if.ep_full      = full_s & ep_act_s;
    bus_if.ep_afull     = afull_s & ep_act_s;
    bus_if.ep_pkt_avail = ~empty_s & ep_act_s;
    bus_if.ovf          = ovf_s & ep_act_s;
    bus_if.udf          = udf_s & ep_act_s;
    bus_if.ep_count     = '0;
    for (int k = 0; k < CNT_CHANNLS; k++) begin
      bus_if.ep_count[k*PTR_W +: PTR_W] = count_s[k];
    end
  end

endmodule

// File: tb/tb_fifo_ep_mst_mc.sv
// Self-checking bench for fifo_ep_mst_mc: scoreboard of expected read addresses
// and pop byte enables, filled at push time and drained at pop time.
module tb_fifo_ep_mst_mc;
  import fifo_ep_mst_mc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_wr [CNT_CHANNLS];
  logic [T_MSZ-1:0]  sb_adr [$];
  logic [CNT_BE-1:0] sb_be  [$];

  fifo_ep_mst_mc_if bus ();

  fifo_ep_mst_mc u_dut (
    .fifoClk_i  (clk),
    .fifoRstn_i (rst_n),
    .bus_if     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [PTR_W-1:0] cnt_of(input int ep);
    return bus.ep_count[ep*PTR_W +: PTR_W];
  endfunction

  function automatic logic [T_MSZ-1:0] adr_of(input int ep, input int w);
    return T_MSZ'(ep * (1 << EP_MSZ) + (w % (1 << EP_MSZ)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int ep, input logic [3:0] be, input logic last,
                           input logic sb_en, input logic [3:0] exp_be);
    logic [T_MSZ-1:0] exp_adr;
    exp_adr = adr_of(ep, m_wr[ep]);
    bus.push_en = 1'b1; bus.push_ep = EP_IDX_W'(ep); bus.push_be = be; bus.push_last = last;
    #1;
    n_vec++;
    if (bus.ram_we !== 1'b1 || bus.ram_wadr !== exp_adr) begin
      n_err++;
      $display("FAIL push_wadr ep%0d word%0d: got we=%b adr=%h, want we=1 adr=%h",
               ep, m_wr[ep], bus.ram_we, bus.ram_wadr, exp_adr);
    end
    if (sb_en) begin
      sb_adr.push_back(exp_adr);
      sb_be.push_back(exp_be);
    end
    tick();
    m_wr[ep]++;
    bus.push_en = 1'b0; bus.push_last = 1'b0;
  endtask

  task automatic pop_word(input int ep);
    logic [T_MSZ-1:0]  e_adr;
    logic [CNT_BE-1:0] e_be;
    bus.pop_en = 1'b1; bus.pop_ep = EP_IDX_W'(ep);
    #1;
    n_vec++;
    if (sb_adr.size() == 0) begin
      n_err++;
      $display("FAIL pop_sb_empty ep%0d: got radr=%h, want a queued entry", ep, bus.ram_radr);
    end else begin
      e_adr = sb_adr.pop_front();
      e_be  = sb_be.pop_front();
      if (bus.ram_radr !== e_adr || bus.pop_be !== e_be) begin
        n_err++;
        $display("FAIL pop_data ep%0d: got radr=%h be=%b, want radr=%h be=%b",
                 ep, bus.ram_radr, bus.pop_be, e_adr, e_be);
      end
    end
    tick();
    bus.pop_en = 1'b0;
  endtask

  task automatic flush_ep(input int ep);
    bus.flush[ep] = 1'b1;
    tick();
    bus.flush = '0;
    m_wr[ep] = 0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (bus.ep_empty !== 4'hF || bus.ep_full !== 4'h0 || bus.ep_afull !== 4'h0 ||
        bus.ep_pkt_avail !== 4'h0 || bus.ovf !== 4'h0 || bus.udf !== 4'h0) begin
      n_err++;
      $display("FAIL reset_flags: got e=%h f=%h af=%h pa=%h ovf=%h udf=%h, want e=f others 0",
               bus.ep_empty, bus.ep_full, bus.ep_afull, bus.ep_pkt_avail, bus.ovf, bus.udf);
    end
    n_vec++;
    if (bus.ep_count !== '0 || bus.ram_we !== 1'b0 || bus.pop_be !== 4'hF) begin
      n_err++;
      $display("FAIL reset_outs: got cnt=%h we=%b pop_be=%b, want 0 0 1111",
               bus.ep_count, bus.ram_we, bus.pop_be);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (bus.ep_empty !== 4'hF || bus.ep_count !== '0) begin
      n_err++;
      $display("FAIL reset_release: got e=%h cnt=%h, want e=f cnt=0", bus.ep_empty, bus.ep_count);
    end
  endtask

  task automatic test_short_pkt();
    for (int i = 0; i < 5; i++) begin
      push_word(1, (i == 4) ? 4'b0011 : 4'b1111, i == 4, 1'b1, (i == 4) ? 4'b0011 : 4'b1111);
    end
    n_vec++;
    if (cnt_of(1) !== 12'd5 || bus.ep_pkt_avail[1] !== 1'b1) begin
      n_err++;
      $display("FAIL short_commit: got cnt=%0d pa=%b, want 5 1", cnt_of(1), bus.ep_pkt_avail[1]);
    end
    for (int i = 0; i < 5; i++) pop_word(1);
    n_vec++;
    if (cnt_of(1) !== 12'd0 || bus.ep_empty[1] !== 1'b1) begin
      n_err++;
      $display("FAIL short_drain: got cnt=%0d e=%b, want 0 1", cnt_of(1), bus.ep_empty[1]);
    end
  endtask

  task automatic test_auto_commit();
    for (int i = 1; i <= PKT_WORDS; i++) begin
      push_word(0, 4'hF, 1'b0, 1'b0, 4'hF);
      if (i == 1 || i == PKT_WORDS - 1) begin
        n_vec++;
        if (cnt_of(0) !== 12'd0) begin
          n_err++;
          $display("FAIL auto_precommit word%0d: got cnt=%0d, want 0", i, cnt_of(0));
        end
      end
    end
    n_vec++;
    if (cnt_of(0) !== 12'd128) begin
      n_err++;
      $display("FAIL auto_commit: got cnt=%0d, want 128", cnt_of(0));
    end
    flush_ep(0);
    n_vec++;
    if (cnt_of(0) !== 12'd0 || bus.ep_empty[0] !== 1'b1) begin
      n_err++;
      $display("FAIL auto_flush: got cnt=%0d e=%b, want 0 1", cnt_of(0), bus.ep_empty[0]);
    end
  endtask

  task automatic test_fill_ovf();
    for (int i = 1; i <= (1 << EP_MSZ); i++) begin
      push_word(2, 4'hF, 1'b0, 1'b0, 4'hF);
      if (i == (1 << EP_MSZ) - AF_LVL - 1 || i == (1 << EP_MSZ) - AF_LVL) begin
        n_vec++;
        if (bus.ep_afull[2] !== (i == (1 << EP_MSZ) - AF_LVL)) begin
          n_err++;
          $display("FAIL afull at %0d words: got %b", i, bus.ep_afull[2]);
        end
      end
    end
    n_vec++;
    if (bus.ep_full[2] !== 1'b1 || cnt_of(2) !== 12'd2048 || bus.ovf[2] !== 1'b0) begin
      n_err++;
      $display("FAIL fill_full: got full=%b cnt=%0d ovf=%b, want 1 2048 0",
               bus.ep_full[2], cnt_of(2), bus.ovf[2]);
    end
    bus.push_en = 1'b1; bus.push_ep = 2'd2; bus.push_last = 1'b1;
    #1;
    n_vec++;
    if (bus.ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_we: got we=%b, want 0", bus.ram_we);
    end
    tick();
    bus.push_en = 1'b0; bus.push_last = 1'b0;
    n_vec++;
    if (bus.ovf[2] !== 1'b1 || bus.ep_full[2] !== 1'b1 || cnt_of(2) !== 12'd2048 ||
        bus.ram_wadr !== adr_of(2, 0)) begin
      n_err++;
      $display("FAIL ovf_state: got ovf=%b full=%b cnt=%0d wadr=%h, want 1 1 2048 %h",
               bus.ovf[2], bus.ep_full[2], cnt_of(2), bus.ram_wadr, adr_of(2, 0));
    end
    flush_ep(2);
    n_vec++;
    if (bus.ovf[2] !== 1'b0 || bus.ep_empty[2] !== 1'b1 || bus.ep_full[2] !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_flush: got ovf=%b e=%b full=%b, want 0 1 0",
               bus.ovf[2], bus.ep_empty[2], bus.ep_full[2]);
    end
  endtask

  task automatic test_udf_simul();
    bus.pop_ep = 2'd3; bus.pop_en = 1'b1;
    tick();
    bus.pop_en = 1'b0;
    n_vec++;
    if (bus.udf[3] !== 1'b1 || bus.ram_radr !== adr_of(3, 0) || bus.ep_empty[3] !== 1'b1) begin
      n_err++;
      $display("FAIL udf: got udf=%b radr=%h e=%b, want 1 %h 1",
               bus.udf[3], bus.ram_radr, bus.ep_empty[3], adr_of(3, 0));
    end
    push_word(0, 4'b0101, 1'b1, 1'b0, 4'hF);
    bus.push_en = 1'b1; bus.push_ep = 2'd0; bus.push_be = 4'hF; bus.push_last = 1'b1;
    bus.pop_en = 1'b1; bus.pop_ep = 2'd0;
    #1;
    n_vec++;
    if (bus.pop_be !== 4'b0101 || bus.ram_radr !== adr_of(0, 0) ||
        bus.ram_wadr !== adr_of(0, 1) || bus.ram_we !== 1'b1) begin
      n_err++;
      $display("FAIL simul_comb: got be=%b radr=%h wadr=%h we=%b, want 0101 %h %h 1",
               bus.pop_be, bus.ram_radr, bus.ram_wadr, bus.ram_we, adr_of(0, 0), adr_of(0, 1));
    end
    tick();
    bus.push_en = 1'b0; bus.push_last = 1'b0; bus.pop_en = 1'b0;
    m_wr[0]++;
    n_vec++;
    if (cnt_of(0) !== 12'd1) begin
      n_err++;
      $display("FAIL simul_count: got cnt=%0d, want 1", cnt_of(0));
    end
    sb_adr.push_back(adr_of(0, 1));
    sb_be.push_back(4'hF);
    pop_word(0);
  endtask

  task automatic test_rewind();
    flush_ep(1);
    for (int i = 0; i < 20; i++) push_word(1, 4'hF, i == 19, 1'b1, 4'hF);
    for (int i = 0; i < 10; i++) pop_word(1);
    n_vec++;
    if (cnt_of(1) !== 12'd10) begin
      n_err++;
      $display("FAIL rewind_pre: got cnt=%0d, want 10", cnt_of(1));
    end
    sb_adr.delete();
    sb_be.delete();
    bus.ld_en = 1'b1; bus.ld_ep = 2'd1; bus.ld_ptr = '0;
    bus.pop_en = 1'b1; bus.pop_ep = 2'd1;
    tick();
    bus.ld_en = 1'b0; bus.pop_en = 1'b0;
    n_vec++;
    if (cnt_of(1) !== 12'd20 || bus.ram_radr !== adr_of(1, 0) || bus.udf[1] !== 1'b0) begin
      n_err++;
      $display("FAIL rewind: got cnt=%0d radr=%h udf=%b, want 20 %h 0",
               cnt_of(1), bus.ram_radr, bus.udf[1], adr_of(1, 0));
    end
  endtask

  task automatic test_mode_flush();
    bus.i_mode = 1'b1;
    bus.push_en = 1'b1; bus.push_ep = 2'd2; bus.push_last = 1'b1;
    #1;
    n_vec++;
    if (bus.ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL mode_we: got we=%b, want 0", bus.ram_we);
    end
    tick();
    bus.push_en = 1'b0; bus.push_last = 1'b0;
    n_vec++;
    if (bus.ep_empty !== 4'b0001 || cnt_of(2) !== 12'd0 || bus.udf !== 4'b0000) begin
      n_err++;
      $display("FAIL mode_flags: got e=%b cnt2=%0d udf=%b, want 0001 0 0000",
               bus.ep_empty, cnt_of(2), bus.udf);
    end
    for (int i = 0; i < 3; i++) push_word(0, 4'hF, 1'b0, 1'b0, 4'hF);
    flush_ep(0);
    bus.pop_ep = 2'd0;
    #1;
    n_vec++;
    if (bus.ep_empty[0] !== 1'b1 || cnt_of(0) !== 12'd0 || bus.ram_radr !== adr_of(0, 0)) begin
      n_err++;
      $display("FAIL flush_mid: got e=%b cnt=%0d radr=%h, want 1 0 %h",
               bus.ep_empty[0], cnt_of(0), bus.ram_radr, adr_of(0, 0));
    end
    push_word(0, 4'hF, 1'b1, 1'b0, 4'hF);
    n_vec++;
    if (cnt_of(0) !== 12'd1) begin
      n_err++;
      $display("FAIL flush_restart: got cnt=%0d, want 1", cnt_of(0));
    end
    bus.i_mode = 1'b0;
  endtask

  task automatic test_async_reset();
    push_word(1, 4'hF, 1'b0, 1'b0, 4'hF);
    push_word(1, 4'hF, 1'b0, 1'b0, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.ep_empty !== 4'hF || bus.ep_count !== '0 || bus.ovf !== 4'h0 ||
        bus.udf !== 4'h0 || bus.ep_full !== 4'h0 || bus.ep_pkt_avail !== 4'h0) begin
      n_err++;
      $display("FAIL async_rst_flags: got e=%h cnt=%h ovf=%h udf=%h f=%h pa=%h",
               bus.ep_empty, bus.ep_count, bus.ovf, bus.udf, bus.ep_full, bus.ep_pkt_avail);
    end
    n_vec++;
    if (bus.ram_we !== 1'b0 || bus.pop_be !== 4'hF) begin
      n_err++;
      $display("FAIL async_rst_outs: got we=%b be=%b, want 0 1111", bus.ram_we, bus.pop_be);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < CNT_CHANNLS; k++) m_wr[k] = 0;
    push_word(1, 4'hF, 1'b1, 1'b0, 4'hF);
    n_vec++;
    if (cnt_of(1) !== 12'd1) begin
      n_err++;
      $display("FAIL post_rst_push: got cnt=%0d, want 1", cnt_of(1));
    end
  endtask

  initial begin
    bus.i_mode = 1'b0; bus.push_en = 1'b0; bus.push_ep = '0; bus.push_be = '0;
    bus.push_last = 1'b0; bus.pop_en = 1'b0; bus.pop_ep = '0; bus.ld_en = 1'b0;
    bus.ld_ep = '0; bus.ld_ptr = '0; bus.flush = '0;
    for (int k = 0; k < CNT_CHANNLS; k++) m_wr[k] = 0;
    test_reset();
    test_short_pkt();
    test_auto_commit();
    test_fill_ovf();
    test_udf_simul();
    test_rewind();
    test_mode_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ep_mst_mc.md
# fifo_ep_mst_mc

Multi-endpoint FIFO master pointer manager for the FT600/FT601 FIFO-bus controller. It generalises the single-endpoint pointer block to N_EP endpoint ring buffers carved from one shared data RAM, with per-endpoint byte-enable tracking. It adds packet commit (data becomes readable only at packet boundaries), fill counts, almost-full flags, flush and sticky overflow/underflow. It sits between the FT60x bus FSM (push side), the USB-side reader (pop side) and the shared dual-port RAM; it generates RAM addresses and write strobes but does not hold data.

## Interface
- N_EP, 4: number of endpoints, 1..8
- EP_MSZ, 11: log2 of words per endpoint ring (no roll-over bit)
- T_MSZ, 14: shared RAM address width; must be ≥ EP_MSZ + clog2(N_EP)
- BE_W, 4: byte-enable width (4 for FT601 32-bit, 2 for FT600 16-bit)
- PKT_WORDS, 128: words per full packet; auto-commit point
- AF_LVL, 8: almost-full when free words ≤ AF_LVL
- EP_BASE_ADR, 0: RAM base; EP k base = EP_BASE_ADR + (k << EP_MSZ)

- fifoClk  in  1  single clock, all logic rising edge
- fifoRstn  in  1  asynchronous, active-low reset
- i_mode  in  1  1 = 245 mode: only EP0 active, other EP flags forced 0, their requests ignored
- push_en  in  1  write one word into push_ep
- push_ep  in  clog2(N_EP)  target endpoint
- push_be  in  BE_W  byte enables of pushed word
- push_last  in  1  pushed word ends a (short) packet
- pop_en  in  1  read one word from pop_ep
- pop_ep  in  clog2(N_EP)  source endpoint
- ld_en  in  1  load read pointer (rewind/retransmit)
- ld_ep  in  clog2(N_EP)  endpoint to load
- ld_ptr  in  EP_MSZ+1  new read pointer incl. roll-over bit
- flush  in  N_EP  per-endpoint synchronous flush
- ram_wadr  out  T_MSZ  RAM write address
- ram_we  out  1  RAM write strobe
- ram_radr  out  T_MSZ  RAM read address
- pop_be  out  BE_W  byte enables of the word at ram_radr
- ep_empty / ep_full / ep_afull / ep_pkt_avail  out  N_EP each  per-endpoint status
- ep_count  out  N_EP*(EP_MSZ+1)  committed readable words per EP, EP k at [k*(EP_MSZ+1) +: EP_MSZ+1]
- ovf / udf  out  N_EP each  sticky overflow / underflow

## Operation
- Per EP registers: wr_ptr, cmt_ptr, rd_ptr (each EP_MSZ+1 bits, MSB = roll-over), pkt_cnt (clog2(PKT_WORDS+1) bits), last_be (BE_W), ovf, udf.
- Free = 2^EP_MSZ − (wr_ptr − rd_ptr); full when wr/rd lower bits equal and MSBs differ. Readable = cmt_ptr − rd_ptr, modulo 2^(EP_MSZ+1).
- Push accepted iff push_en, EP valid for mode, not full, no flush on that EP: ram_we=1, ram_wadr=base+wr_ptr[EP_MSZ-1:0], wr_ptr+1, pkt_cnt+1, last_be←push_be.
- Commit on accepted push when push_last or pkt_cnt+1 == PKT_WORDS: cmt_ptr←wr_ptr+1, pkt_cnt←0.
- Push rejected when full: no write, ovf set; push_last on a rejected push does not commit.
- Pop accepted iff pop_en, readable>0: rd_ptr+1. pop_en with readable==0: no change, udf set.
- ram_radr = base(pop_ep)+rd_ptr[EP_MSZ-1:0] always; pop_be = last_be of pop_ep when readable==1 and cmt_ptr==wr_ptr, else all ones.
- ld_en: rd_ptr←ld_ptr; overrides pop on same EP same cycle. ld_ptr outside [rd_ptr..cmt_ptr] is caller error, not checked.
- flush[k]: wr_ptr, cmt_ptr, rd_ptr, pkt_cnt ←0, last_be←0, ovf/udf cleared; overrides push/pop/ld on EP k.
- Flags: ep_empty = readable==0; ep_full; ep_afull = free≤AF_LVL; ep_pkt_avail = readable≠0.
- Push and pop on same EP same cycle: both act; pop sees pre-push cmt_ptr.

## Timing
- ram_wadr/ram_we/ram_radr/pop_be combinational from request + current registers (same cycle).
- Pointers update at the rising edge; status outputs are combinational from registers, so they reflect an event one cycle after it.
- Reset (async assert, sync-free release): all pointers, pkt_cnt, last_be, ovf, udf = 0; ep_empty = all ones, all other flags 0, ep_count 0, ram_we 0, pop_be all ones.
- Wrap: lower bits wrap at 2^EP_MSZ, MSB toggles; no flag glitch at wrap.

## Structure
- Shared package pkg_ft601_ctrl_defines: CNT_CHANNLS, CNT_BE, EP index width, ep_state_t struct (wr_ptr, cmt_ptr, rd_ptr, pkt_cnt, last_be, ovf, udf).
- One sub-module, fifo_ep_ring: single-EP pointer/flag logic, instantiated N_EP times via generate; top does request decode and address/pop_be muxing.

## Test plan
- Reset, then push 5 words to EP1 with push_last on word 5, push_be=4'b0011 last -> ep_count[1]=5, ep_pkt_avail[1]=1, popping 5 gives pop_be=4'b1111 ×4 then 4'b0011.
- Push PKT_WORDS=128 words to EP0 without push_last -> ep_count[0] goes 0 until word 128 accepted, then 128.
- Fill EP2 to 2^EP_MSZ=2048, push once more -> ep_full[2]=1, ovf[2]=1, wr_ptr unchanged; ep_afull[2] asserted at 2040 words.
- Pop empty EP3 -> udf[3]=1, ram_radr unchanged; simultaneous push+pop on EP0 with 1 readable -> count stays 1 after commit.
- Read 10 of 20 committed words on EP1, ld_en with ld_ptr=0 and pop_en same cycle -> rd_ptr=0, ep_count[1]=20.
- i_mode=1: push to EP2 ignored, ep_empty[2]=0; flush[0] mid-packet -> EP0 pointers 0, empty; assert fifoRstn low mid-traffic -> all outputs at reset values immediately.
